cfnp_batch_sequencer: RTL and testbench

//   Batch controller for the CFNP inference core. One start launches the core over a run of

---
 rtl/cfnp_batch_sequencer_if.sv | 28 ++
 rtl/cfnp_batch_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cfnp_batch_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfnp_batch_sequencer_if.sv
// Handshake bundle between the batch sequencer, its host, the CFNP core and the result consumer.
interface cfnp_batch_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  logic              start;
  logic [CNT_W-1:0]  num_windows;
  logic              core_start;
  logic [CNT_W-1:0]  win_idx;
  logic              core_done;
  logic [DATA_W-1:0] core_odata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err_timeout;

  modport master (
    output start, num_windows, core_done, core_odata, out_ready,
    input  core_start, win_idx, out_data, out_valid, busy, done, err_timeout
  );

  modport slave (
    input  start, num_windows, core_done, core_odata, out_ready,
    output core_start, win_idx, out_data, out_valid, busy, done, err_timeout
  );
endinterface

// File: rtl/cfnp_batch_sequencer.sv
// Runs the CFNP core over a batch of windows, smooths each result and queues it in a FWFT FIFO.
module cfnp_batch_sequencer #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int AVG_LOG2   = 0,
  parameter int TIMEOUT    = 4095
) (
  input logic                    clk,
  input logic                    rst,
  cfnp_batch_sequencer_if.slave  bus
);
  localparam int HIST_N = 1 << AVG_LOG2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam logic [PTR_W:0]   FIFO_FULL = FIFO_DEPTH[PTR_W:0];
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_STORE, S_FINISH} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         win_idx_q, win_idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [DATA_W-1:0]        res_q, res_d;
  logic signed [DATA_W-1:0] hist_q [HIST_N];
  logic signed [DATA_W-1:0] hist_d [HIST_N];
  logic                     primed_q, primed_d;
  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           fcnt_q, fcnt_d;
  logic                     core_start_q, core_start_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  logic                     full, empty, push, pop;
  logic signed [DATA_W-1:0] hist_new [HIST_N];
  logic signed [SUM_W-1:0]  sum, avg_shift;
  logic [DATA_W-1:0]        avg;

  always_comb begin
    full  = (fcnt_q == FIFO_FULL);
    empty = (fcnt_q == '0);
    pop   = !empty && bus.out_ready;
    push  = (state_q == S_STORE) && !full;

    // The first result of a batch fills the whole history so the average starts at that value.
    hist_new[0] = res_q;
    for (int i = 1; i < HIST_N; i++) hist_new[i] = primed_q ? hist_q[i-1] : res_q;
    sum = '0;
    for (int i = 0; i < HIST_N; i++) sum = sum + SUM_W'(hist_new[i]);
    avg_shift = sum >>> AVG_LOG2;
    avg       = avg_shift[DATA_W-1:0];

    state_d      = state_q;
    count_d      = count_q;
    win_idx_d    = win_idx_q;
    tmo_d        = tmo_q;
    res_d        = res_q;
    hist_d       = hist_q;
    primed_d     = primed_q;
    err_d        = err_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_windows != '0) begin
            count_d      = bus.num_windows;
            win_idx_d    = '0;
            err_d        = 1'b0;
            primed_d     = 1'b0;
            core_start_d = 1'b1;
            state_d      = S_LAUNCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        tmo_d   = TMO_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          res_d   = bus.core_odata;
          state_d = S_STORE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_STORE: begin
        if (!full) begin
          hist_d   = hist_new;
          primed_d = 1'b1;
          if (win_idx_q == count_q - 1'b1) begin
            state_d = S_FINISH;
          end else begin
            win_idx_d    = win_idx_q + 1'b1;
            core_start_d = 1'b1;
            state_d      = S_LAUNCH;
          end
        end
      end
      S_FINISH: begin
        if (empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = avg;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      win_idx_q    <= '0;
      tmo_q        <= '0;
      res_q        <= '0;
      primed_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      win_idx_q    <= win_idx_d;
      tmo_q        <= tmo_d;
      res_q        <= res_d;
      primed_q     <= primed_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      hist_q       <= hist_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.core_start  = core_start_q;
  assign bus.win_idx     = win_idx_q;
  assign bus.out_data    = mem_q[rd_ptr_q];
  assign bus.out_valid   = !empty;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_cfnp_batch_sequencer.sv
// Bench for cfnp_batch_sequencer: two instances (bypass and 2-deep average) share one stimulus and core model.
module tb_cfnp_batch_sequencer;
  localparam int DW  = 16;
  localparam int CW  = 5;
  localparam int FD  = 4;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfnp_batch_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) if0 ();
  cfnp_batch_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) if1 ();

  cfnp_batch_sequencer #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(FD), .AVG_LOG2(0), .TIMEOUT(TMO))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  cfnp_batch_sequencer #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(FD), .AVG_LOG2(1), .TIMEOUT(TMO))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state: the core answers each launch after a delay; expected FIFO
  // contents are derived from the sequence of answers.
  int  pend = 0;
  bit  rand_delay = 1'b0;
  int  silent_from = 99;
  int  fixed_vals[$];
  int  exp0[$];
  int  exp1[$];
  int  prev_res = 0;
  bit  first_res = 1'b1;
  int  cs0 = 0, cs1 = 0;
  int  pops0 = 0, pops1 = 0;
  int  dones0 = 0, dones1 = 0;
  int  cyc = 0, cs_cyc = 0;
  bit  err_prev = 1'b0;
  int  v, a;
  logic [DW-1:0] r;

  initial begin
    if0.core_done = 1'b0; if1.core_done = 1'b0;
    if0.core_odata = '0;  if1.core_odata = '0;
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 0;
      if0.core_done = 1'b0; if1.core_done = 1'b0;
      exp0.delete(); exp1.delete();
      err_prev = 1'b0;
    end else begin
      if (if0.out_valid && if0.out_ready) begin
        if (exp0.size() == 0) check_val("pop0_unexpected", 1, 0);
        else check_val("out_data0", $signed(if0.out_data), exp0.pop_front());
        pops0++;
      end
      if (if1.out_valid && if1.out_ready) begin
        if (exp1.size() == 0) check_val("pop1_unexpected", 1, 0);
        else check_val("out_data1", $signed(if1.out_data), exp1.pop_front());
        pops1++;
      end
      if (if0.core_start) begin
        check_val("win_idx0", if0.win_idx, cs0);
        check_val("busy_at_launch0", if0.busy, 1);
        cs0++;
        cs_cyc = cyc;
      end
      if (if1.core_start) begin
        check_val("win_idx1", if1.win_idx, cs1);
        cs1++;
      end
      if (if0.done) begin
        dones0++;
        check_val("done_busy0", if0.busy, 0);
        check_val("done_drained0", if0.out_valid, 0);
      end
      if (if1.done) begin
        dones1++;
        check_val("done_drained1", if1.out_valid, 0);
      end
      if (if0.err_timeout && !err_prev) check_val("timeout_latency", cyc - cs_cyc, TMO + 1);
      err_prev = if0.err_timeout;

      if0.core_done = 1'b0; if1.core_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (fixed_vals.size() > 0) begin
            v = fixed_vals.pop_front();
            r = v[DW-1:0];
          end else begin
            r = DW'($urandom);
            v = int'($signed(r));
          end
          if0.core_odata = r; if1.core_odata = r;
          if0.core_done = 1'b1; if1.core_done = 1'b1;
          exp0.push_back(v);
          a = first_res ? v : ((v + prev_res) >>> 1);
          exp1.push_back(a);
          prev_res  = v;
          first_res = 1'b0;
        end
      end
      if (if0.core_start && (cs0 - 1) < silent_from)
        pend = rand_delay ? int'($urandom_range(1, 15)) : 10;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input bit s, input int num);
    if0.start = s; if1.start = s;
    if0.num_windows = CW'(num); if1.num_windows = CW'(num);
  endtask

  task automatic set_ready(input bit rdy);
    if0.out_ready = rdy; if1.out_ready = rdy;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_core_start0"}, if0.core_start, 0);
    check_val({tag, "_win_idx0"}, if0.win_idx, 0);
    check_val({tag, "_out_data0"}, if0.out_data, 0);
    check_val({tag, "_out_valid0"}, if0.out_valid, 0);
    check_val({tag, "_busy0"}, if0.busy, 0);
    check_val({tag, "_done0"}, if0.done, 0);
    check_val({tag, "_err0"}, if0.err_timeout, 0);
    check_val({tag, "_out_valid1"}, if1.out_valid, 0);
    check_val({tag, "_busy1"}, if1.busy, 0);
    check_val({tag, "_win_idx1"}, if1.win_idx, 0);
  endtask

  task automatic wait_done(input int base, input bit rand_rdy);
    bit got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (dones0 != base) begin
        got = 1'b1;
        break;
      end
      step();
      if (rand_rdy) set_ready(1'($urandom_range(0, 1)));
    end
    check_val("batch_done_seen", got, 1);
  endtask

  // rdy_mode: 1 = always ready, 2 = random backpressure
  task automatic run_batch(input int num, input int rdy_mode, input bit spam,
                           input int exp_pops, input int exp_cs);
    int d0 = dones0, d1 = dones1, p0 = pops0, p1 = pops1;
    bit got = 1'b0;
    cs0 = 0; cs1 = 0; first_res = 1'b1;
    set_ready(rdy_mode == 1);
    drive_start(1'b1, num);
    step();
    drive_start(1'b0, num);
    check_val("launch_latency", if0.core_start, 1);
    check_val("err_cleared", if0.err_timeout, 0);
    for (int k = 0; k < 3000; k++) begin
      if (dones0 != d0) begin
        got = 1'b1;
        break;
      end
      step();
      if (rdy_mode == 2) set_ready(1'($urandom_range(0, 1)));
      if (spam && k < 20) drive_start(k % 5 == 2, 1);
      else drive_start(1'b0, num);
    end
    check_val("batch_done_seen", got, 1);
    set_ready(1'b1);
    step(); step();
    check_val("done_pulses0", dones0 - d0, 1);
    check_val("done_pulses1", dones1 - d1, 1);
    check_val("pops0", pops0 - p0, exp_pops);
    check_val("pops1", pops1 - p1, exp_pops);
    check_val("core_starts0", cs0, exp_cs);
    check_val("core_starts1", cs1, exp_cs);
  endtask

  initial begin
    int num, d0, p0;
    drive_start(1'b0, 0);
    set_ready(1'b0);
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // bypass vs 2-deep average on a fixed sequence, with ignored start pulses while busy
    fixed_vals = '{100, 200, -300};
    run_batch(3, 1, 1'b1, 3, 3);

    rand_delay = 1'b1;
    for (int b = 0; b < 6; b++) begin
      num = $urandom_range(1, 8);
      run_batch(num, 2, 1'b0, num, num);
    end

    // FIFO fills, fifth result stalls in STORE until the consumer drains
    rand_delay = 1'b0;
    cs0 = 0; cs1 = 0; first_res = 1'b1;
    d0 = dones0; p0 = pops0;
    set_ready(1'b0);
    drive_start(1'b1, 6);
    step();
    drive_start(1'b0, 6);
    repeat (200) step();
    check_val("stall_core_starts0", cs0, 5);
    check_val("stall_core_starts1", cs1, 5);
    check_val("stall_no_pops", pops0 - p0, 0);
    check_val("stall_out_valid", if0.out_valid, 1);
    check_val("stall_busy", if0.busy, 1);
    set_ready(1'b1);
    wait_done(d0, 1'b0);
    step(); step();
    check_val("stall_total_pops", pops0 - p0, 6);
    check_val("stall_total_starts", cs0, 6);

    // core never answers
    silent_from = 0;
    run_batch(2, 1, 1'b0, 0, 1);
    check_val("timeout_err", if0.err_timeout, 1);
    check_val("timeout_win_idx", if0.win_idx, 0);
    // core answers window 0 only; that result is still delivered
    silent_from = 1;
    run_batch(3, 1, 1'b0, 1, 2);
    check_val("timeout2_err", if1.err_timeout, 1);
    check_val("timeout2_win_idx", if0.win_idx, 1);
    silent_from = 99;
    run_batch(1, 1, 1'b0, 1, 1);

    // zero-length batch
    cs0 = 0;
    d0 = dones0;
    drive_start(1'b1, 0);
    step();
    drive_start(1'b0, 0);
    check_val("zero_done", if0.done, 1);
    check_val("zero_busy", if0.busy, 0);
    step();
    check_val("zero_done_single", if0.done, 0);
    repeat (3) step();
    check_val("zero_no_launch", cs0, 0);
    check_val("zero_done_count", dones0 - d0, 1);

    // reset while waiting on window 1
    cs0 = 0; cs1 = 0; first_res = 1'b1;
    set_ready(1'b1);
    drive_start(1'b1, 3);
    step();
    drive_start(1'b0, 3);
    for (int k = 0; k < 200 && cs0 < 2; k++) step();
    check_val("rst_reached_win1", cs0, 2);
    repeat (3) step();
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (30) step();
    check_val("midrst_no_launch", cs0, 2);
    run_batch(2, 1, 1'b0, 2, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
